// File: rtl/fifo_share_pkg.sv
// Shared definitions for the shared-FIFO controller: default sizes and read-FSM states.
package fifo_share_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefDepth = 16;

  // RdEmpty: output register empty; RdFetch: RAM read in flight; RdHold: output word presented
  typedef enum logic [1:0] {
    RdEmpty = 2'd0,
    RdFetch = 2'd1,
    RdHold  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_ram_dp.sv
// Simple dual-port RAM: one write port, one read port with registered read data.
// Storage is not reset; contents are only meaningful once written.
module fifo_ram_dp
  import fifo_share_pkg::*;
#(
  parameter int unsigned Depth = DefDepth,
  parameter int unsigned DataW = DefDataW
) (
  input  logic                     clk_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(Depth)-1:0] wr_addr_i,
  input  logic [DataW-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(Depth)-1:0] rd_addr_i,
  output logic [DataW-1:0]         rd_data_o
);

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rd_data_d, rd_data_q;

  // Read data only updates when a read is issued, so the last fetched word stays put
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      rd_data_d = mem_q[rd_addr_i];
    end
  end

  // Storage array and read register, no reset
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_share_ctrl.sv
// Shared-FIFO controller: round-robin arbitration with a burst cap over NUM_REQ producers,
// a DEPTH-entry RAM buffer and a valid/ready output register drained by a small read FSM.
module fifo_share_ctrl
  import fifo_share_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned DEPTH     = DefDepth,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        full,
  output logic                        empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned BW = $clog2(BURST_MAX + 1);

  logic [GW-1:0]     gnt_q, gnt_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  rd_state_e         rd_state_q, rd_state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic [NUM_REQ-1:0] gnt_oh;
  logic [GW-1:0]      gnt_idx;
  logic [GW-1:0]      scan_g;
  logic               gnt_found;
  logic               others_valid;
  logic               wr_en;
  logic [DATA_W-1:0]  wr_data;
  logic               rd_issue;
  logic [DATA_W-1:0]  ram_rdata;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  // Arbiter: holder keeps the grant within its burst budget, else round-robin from holder+1.
  // A zero burst counter means no tenure yet, which lets producer 0 win first after reset.
  always_comb begin
    gnt_oh       = '0;
    gnt_idx      = gnt_q;
    gnt_found    = 1'b0;
    scan_g       = '0;
    others_valid = |(req_valid & ~(NUM_REQ'(1) << gnt_q));
    if (!full) begin
      if ((burst_q != '0) && req_valid[gnt_q] &&
          ((burst_q < BW'(BURST_MAX)) || !others_valid)) begin
        gnt_found = 1'b1;
      end else begin
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
          scan_g = GW'((32'(gnt_q) + k) % NUM_REQ);
          if (!gnt_found && req_valid[scan_g]) begin
            gnt_found = 1'b1;
            gnt_idx   = scan_g;
          end
        end
      end
    end
    if (gnt_found) begin
      gnt_oh[gnt_idx] = 1'b1;
    end
  end

  // Reset also forces ready low so nothing looks accepted while the block is held in reset
  assign req_ready = rst_n ? gnt_oh : '0;
  assign wr_en     = |req_ready;

  // Select the granted producer's word
  always_comb begin
    wr_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == GW'(i)) begin
        wr_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Write side: pointer advance, grant holder and burst counter update on accept
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    gnt_d    = gnt_q;
    burst_d  = burst_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      gnt_d    = gnt_idx;
      if (gnt_idx != gnt_q) begin
        burst_d = BW'(1);
      end else if (burst_q < BW'(BURST_MAX)) begin
        burst_d = burst_q + BW'(1);
      end
    end
  end

  // Read FSM: fetch from RAM into the output register, one word per two cycles at best
  always_comb begin
    rd_state_d  = rd_state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rd_issue    = 1'b0;
    unique case (rd_state_q)
      RdEmpty: begin
        if (!empty) begin
          rd_issue   = 1'b1;
          rd_state_d = RdFetch;
        end
      end
      RdFetch: begin
        out_data_d  = ram_rdata;
        out_valid_d = 1'b1;
        rd_state_d  = RdHold;
      end
      RdHold: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!empty) begin
            rd_issue   = 1'b1;
            rd_state_d = RdFetch;
          end else begin
            rd_state_d = RdEmpty;
          end
        end
      end
      default: rd_state_d = RdEmpty;
    endcase
  end

  // Read pointer and occupancy bookkeeping
  always_comb begin
    rd_ptr_d = rd_issue ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({wr_en, rd_issue})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q       <= GW'(NUM_REQ - 1);
      burst_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_state_q  <= RdEmpty;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      gnt_q       <= gnt_d;
      burst_q     <= burst_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rd_state_q  <= rd_state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  fifo_ram_dp #(
    .Depth (DEPTH),
    .DataW (DATA_W)
  ) u_ram (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_issue),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (ram_rdata)
  );

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = level_q;

endmodule

// File: tb/tb_fifo_share_ctrl.sv
// Directed bench for fifo_share_ctrl with a data scoreboard fed by observed producer accepts.
module tb_fifo_share_ctrl;

  localparam int unsigned NR = 2;
  localparam int unsigned DW = 16;
  localparam int unsigned DP = 16;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_ready;
  logic [4:0]       level;
  logic             full;
  logic             empty;

  fifo_share_ctrl #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .DEPTH     (DP),
    .BURST_MAX (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int n_deliv = 0;
  int cyc_cnt = 0;

  logic [DW-1:0] exp_q[$];
  int            acc_log[$];
  int            acc_cyc[$];

  int            p_left [NR];
  logic [DW-1:0] p_next [NR];
  logic          rand_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: push accepted words, pop and compare delivered words
  initial begin
    forever begin
      @(negedge clk);
      cyc_cnt++;
      if (rst_n) begin
        for (int i = 0; i < NR; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            exp_q.push_back(req_data[i*DW +: DW]);
            acc_log.push_back(i);
            acc_cyc.push_back(cyc_cnt);
          end
        end
        if (out_valid && out_ready) begin
          check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
          end
          n_deliv++;
        end
      end
    end
  end

  task automatic drive_prod();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]           = (p_left[i] > 0);
      req_data[i*DW +: DW]   = p_next[i];
    end
  endtask

  // One clock: sample accepts at negedge, advance producers just after the posedge
  task automatic cyc();
    logic [NR-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        p_left[i]--;
        p_next[i]++;
      end
    end
    drive_prod();
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_deliv(input int n, input int budget, input string tag);
    int k = 0;
    while (n_deliv < n && k < budget) begin
      cyc();
      k++;
    end
    check(tag, n_deliv, n);
  endtask

  task automatic clear_bench();
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    rand_rdy  = 1'b0;
    for (int i = 0; i < NR; i++) begin
      p_left[i] = 0;
      p_next[i] = '0;
    end
    exp_q.delete();
    acc_log.delete();
    acc_cyc.delete();
    n_deliv = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_bench();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [16:0] pat;

  initial begin
    rst_n = 1'b0;
    do_reset();

    // Reset state
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);

    // Single producer, latency of first word
    p_left[0] = 5;
    p_next[0] = 16'h0001;
    out_ready = 1'b1;
    drive_prod();
    #1;
    check("t1_ready_p0", 32'(req_ready), 32'd1);
    cyc();
    check("t1_level_after_wr", 32'(level), 32'd1);
    check("t1_valid_n0", 32'(out_valid), 32'd0);
    cyc();
    check("t1_valid_n1", 32'(out_valid), 32'd0);
    cyc();
    check("t1_valid_n2", 32'(out_valid), 32'd1);
    check("t1_data_n2", 32'(out_data), 32'h0001);
    wait_deliv(5, 60, "t1_delivered");
    repeat (2) cyc();
    check("t1_empty", 32'(empty), 32'd1);
    check("t1_out_valid_end", 32'(out_valid), 32'd0);
    check("t1_sb_drained", 32'(exp_q.size()), 32'd0);

    // Fairness with stalled consumer, then fill to full
    do_reset();
    p_left[0] = 100;
    p_next[0] = 16'h1000;
    p_left[1] = 100;
    p_next[1] = 16'h2000;
    drive_prod();
    repeat (20) cyc();
    check("t2_accept_count", 32'(acc_log.size()), 32'd17);
    pat = '0;
    for (int k = 0; k < 17 && k < acc_log.size(); k++) pat[k] = 1'(acc_log[k]);
    check("t2_grant_order", 32'(pat), 32'h0F0F0);
    check("t2_level_full", 32'(level), 32'd16);
    check("t2_full", 32'(full), 32'd1);
    check("t2_ready_full", 32'(req_ready), 32'd0);
    check("t2_head_valid", 32'(out_valid), 32'd1);
    check("t2_head_data", 32'(out_data), 32'h1000);

    // Full boundary: one read frees a slot, P1 gets it the next cycle
    p_left[0] = 0;
    p_left[1] = 1;
    out_ready = 1'b1;
    drive_prod();
    #1;
    check("t3_ready_while_full", 32'(req_ready), 32'd0);
    cyc();
    check("t3_level_15", 32'(level), 32'd15);
    check("t3_not_full", 32'(full), 32'd0);
    check("t3_ready_p1", 32'(req_ready), 32'd2);
    cyc();
    check("t3_level_16", 32'(level), 32'd16);
    wait_deliv(18, 120, "t3_delivered");
    repeat (2) cyc();
    check("t3_sb_drained", 32'(exp_q.size()), 32'd0);
    check("t3_empty", 32'(empty), 32'd1);

    // Wrap: 40 words through one producer with random consumer back-pressure
    do_reset();
    p_left[0] = 40;
    p_next[0] = 16'h0100;
    rand_rdy  = 1'b1;
    out_ready = 1'b1;
    drive_prod();
    wait_deliv(40, 600, "t4_delivered");
    check("t4_sb_drained", 32'(exp_q.size()), 32'd0);

    // Holder goes idle: P1 picks up on the very cycle P0 drops
    do_reset();
    p_left[0] = 2;
    p_next[0] = 16'h5000;
    p_left[1] = 3;
    p_next[1] = 16'h6000;
    out_ready = 1'b1;
    drive_prod();
    cyc();
    cyc();
    #1;
    check("t5_ready_p1", 32'(req_ready), 32'd2);
    wait_deliv(5, 60, "t5_delivered");
    pat = '0;
    for (int k = 0; k < 5 && k < acc_log.size(); k++) pat[k] = 1'(acc_log[k]);
    check("t5_grant_order", 32'(pat), 32'b11100);
    if (acc_cyc.size() >= 3) begin
      check("t5_no_gap", 32'(acc_cyc[2] - acc_cyc[1]), 32'd1);
    end else begin
      check("t5_accepts_seen", 32'(acc_cyc.size()), 32'd5);
    end

    // Asynchronous reset mid-stream
    do_reset();
    p_left[0] = 20;
    p_next[0] = 16'h0700;
    drive_prod();
    repeat (8) cyc();
    check("t6_pre_level", 32'(level), 32'd7);
    check("t6_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_data", 32'(out_data), 32'd0);
    check("t6_rst_level", 32'(level), 32'd0);
    check("t6_rst_empty", 32'(empty), 32'd1);
    check("t6_rst_full", 32'(full), 32'd0);
    check("t6_rst_ready", 32'(req_ready), 32'd0);
    exp_q.delete();
    acc_log.delete();
    n_deliv   = 0;
    p_left[0] = 3;
    p_next[0] = 16'h0A00;
    drive_prod();
    @(posedge clk);
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    wait_deliv(3, 60, "t6_delivered");
    repeat (2) cyc();
    check("t6_sb_drained", 32'(exp_q.size()), 32'd0);
    check("t6_empty", 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
